// File: rtl/ref_seq_pkg.sv
// Package: ref_seq_pkg
// Shared definitions for the reference burst sequencer: FSM state encoding
// and default parameter values used by the top level and its timer.
package ref_seq_pkg;

  localparam int PULSE_W_DEF = 4;   // ref_signal high time in cycles
  localparam int CNT_W_DEF   = 32;  // period / delay counter width
  localparam int IDX_W_DEF   = 16;  // pulse_count / pulse_idx width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ref_down_timer.sv
// Module: ref_down_timer
// Loadable down counter with a zero flag. A load wins over a decrement in
// the same cycle; decrementing stops at zero so the count never wraps.
// Ports:
//   clk       system clock
//   reset     synchronous, active-high; clears the count
//   load      load load_val this cycle
//   dec       decrement by one this cycle (ignored when load is high)
//   load_val  value to load
//   count     current count
//   zero      high while count == 0
module ref_down_timer #(
  parameter int CNT_W = ref_seq_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ref_burst_sequencer.sv
// Module: ref_burst_sequencer
// Emits a burst of pulse_count reference pulses, each PULSE_W cycles high,
// spaced sig_period cycles apart, after start_delay cycles. A burst is armed
// by a rising edge of start while idle; configuration is latched then.
// Ports:
//   clk          system clock
//   reset        synchronous, active-high; highest priority
//   start        level input, rising edge arms a burst when idle
//   abort        returns to idle at the next edge, suppresses done
//   sig_period   pulse spacing (clamped to at least PULSE_W+1), latched
//   start_delay  cycles from arming edge to first pulse, used at arm
//   pulse_count  pulses per burst, latched
//   ref_signal   registered reference pulse output
//   busy         high while a burst is delaying or pulsing
//   done         one-cycle strobe after the last gap of a burst
//   pulse_idx    0-based index of the current / last pulse
module ref_burst_sequencer
  import ref_seq_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] sig_period,
  input  logic [CNT_W-1:0] start_delay,
  input  logic [IDX_W-1:0] pulse_count,
  output logic             ref_signal,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] pulse_idx
);

  localparam logic [CNT_W-1:0] PW      = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(PULSE_W + 1);

  state_t           state, state_nxt;
  logic             start_r;
  logic             arm;
  logic [CNT_W-1:0] per_q;
  logic [IDX_W-1:0] n_q;

  logic             t_load, t_dec, t_zero;
  logic [CNT_W-1:0] t_val, t_count;
  logic             idx_clr, idx_inc;

  assign arm = start & ~start_r & (state == IDLE);

  ref_down_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (t_val),
    .count    (t_count),
    .zero     (t_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_dec     = 1'b0;
    t_val     = '0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          idx_clr = 1'b1;
          if (pulse_count == '0) begin
            state_nxt = DONE;
          end else if (start_delay == '0) begin
            state_nxt = PULSE;
            t_load    = 1'b1;
            t_val     = PW - CNT_W'(1);
          end else begin
            state_nxt = DELAY;
            t_load    = 1'b1;
            t_val     = start_delay - CNT_W'(1);
          end
        end
      end
      DELAY: begin
        if (t_zero) begin
          state_nxt = PULSE;
          t_load    = 1'b1;
          t_val     = PW - CNT_W'(1);
        end else begin
          t_dec = 1'b1;
        end
      end
      PULSE: begin
        if (t_zero) begin
          // per_q >= PULSE_W+1, so the gap length cannot underflow.
          state_nxt = GAP;
          t_load    = 1'b1;
          t_val     = per_q - PW - CNT_W'(1);
        end else begin
          t_dec = 1'b1;
        end
      end
      GAP: begin
        if (t_zero) begin
          if (pulse_idx == n_q - IDX_W'(1)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = PULSE;
            t_load    = 1'b1;
            t_val     = PW - CNT_W'(1);
            idx_inc   = 1'b1;
          end
        end else begin
          t_dec = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything, including an arm in the same cycle.
    if (abort) begin
      state_nxt = IDLE;
      t_load    = 1'b0;
      t_dec     = 1'b0;
      idx_clr   = 1'b0;
      idx_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      // Track the level during reset so a start held high across reset is
      // not mistaken for a fresh rising edge on release.
      start_r    <= start;
      per_q      <= MIN_PER;
      n_q        <= '0;
      pulse_idx  <= '0;
      ref_signal <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_r <= start;
      if (arm && !abort) begin
        per_q <= (sig_period < MIN_PER) ? MIN_PER : sig_period;
        n_q   <= pulse_count;
      end
      if (idx_clr) begin
        pulse_idx <= '0;
      end else if (idx_inc) begin
        pulse_idx <= pulse_idx + IDX_W'(1);
      end
      // Outputs are registered from the current state: one cycle behind it.
      ref_signal <= (state == PULSE) && !abort;
      busy       <= (state inside {DELAY, PULSE, GAP}) && !abort;
      done       <= (state == DONE) && !abort;
    end
  end

endmodule

// File: tb/tb_ref_burst_sequencer.sv
// Testbench: tb_ref_burst_sequencer
// Scoreboard bench for ref_burst_sequencer. Each arm pushes the expected
// pulse rise cycles, pulse indices and done cycle; a negedge monitor pops
// and compares them as the DUT produces them, and checks busy each cycle.
module tb_ref_burst_sequencer;

  localparam int PULSE_W = 4;
  localparam int CNT_W   = 32;
  localparam int IDX_W   = 16;

  logic             clk = 1'b0;
  logic             reset, start, abort;
  logic [CNT_W-1:0] sig_period, start_delay;
  logic [IDX_W-1:0] pulse_count;
  logic             ref_signal, busy, done;
  logic [IDX_W-1:0] pulse_idx;

  ref_burst_sequencer #(.PULSE_W(PULSE_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .sig_period  (sig_period),
    .start_delay (start_delay),
    .pulse_count (pulse_count),
    .ref_signal  (ref_signal),
    .busy        (busy),
    .done        (done),
    .pulse_idx   (pulse_idx)
  );

  always #5 clk = ~clk;

  // cyc equals the number of the most recent posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  int exp_rise[$];
  int exp_idx[$];
  int exp_done[$];
  int busy_lo = 1;
  int busy_hi = 0;
  bit mon_en = 1'b0;
  bit width_skip = 1'b0;
  int hi_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: sampled on the falling edge, half a cycle away from the DUT edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (ref_signal === 1'b1) begin
        if (hi_cnt == 0) begin
          if (exp_rise.size() == 0) begin
            check("unexp_rise", 32'(ref_signal), 0);
          end else begin
            check("rise_time", cyc, exp_rise.pop_front());
            check("rise_idx", 32'(pulse_idx), exp_idx.pop_front());
          end
        end
        hi_cnt++;
      end else begin
        if (hi_cnt != 0 && !width_skip) check("pulse_w", hi_cnt, PULSE_W);
        hi_cnt = 0;
      end
      if (done === 1'b1) begin
        if (exp_done.size() == 0) check("unexp_done", 32'(done), 0);
        else                      check("done_time", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive a fresh rising edge of start with the given config and push the
  // expected burst. t returns the arming edge number.
  task automatic arm(input int per, input int dly, input int n, output int t);
    int pe;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    sig_period  = per;
    start_delay = dly;
    pulse_count = n;
    start       = 1'b1;
    width_skip  = 1'b0;
    t  = cyc + 1;
    pe = (per < PULSE_W + 1) ? PULSE_W + 1 : per;
    for (int k = 0; k < n; k++) begin
      exp_rise.push_back(t + 1 + dly + k * pe);
      exp_idx.push_back(k);
    end
    busy_lo = t + 1;
    if (n == 0) begin
      exp_done.push_back(t + 1);
      busy_hi = t;
    end else begin
      exp_done.push_back(t + 1 + dly + n * pe);
      busy_hi = t + dly + n * pe;
    end
  endtask

  task automatic end_burst(input int t_done, input int n);
    wait_until(t_done + 2);
    check("rise_left", exp_rise.size(), 0);
    check("done_left", exp_done.size(), 0);
    check("idx_end", 32'(pulse_idx), (n == 0) ? 0 : n - 1);
  endtask

  // Abort (or reset) asserted for one edge starting at the current negedge.
  task automatic kill(input bit use_reset);
    if (use_reset) reset = 1'b1;
    else           abort = 1'b1;
    if (busy_hi > cyc) busy_hi = cyc;
    exp_rise.delete();
    exp_idx.delete();
    exp_done.delete();
    width_skip = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;
    check("kill_ref", 32'(ref_signal), 0);
    check("kill_busy", 32'(busy), 0);
    check("kill_done", 32'(done), 0);
    if (use_reset) check("rst_idx", 32'(pulse_idx), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: stuck at cycle %0d, expected bench to finish", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1; start = 1'b1; abort = 1'b0;
    sig_period = 10; start_delay = 0; pulse_count = 3;

    // 1: reset with start held high; nothing may arm after release.
    repeat (3) @(negedge clk);
    check("rst_ref", 32'(ref_signal), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_idx", 32'(pulse_idx), 0);
    mon_en = 1'b1;
    reset  = 1'b0;
    repeat (10) @(negedge clk);
    check("no_arm_busy", 32'(busy), 0);
    check("no_arm_done_q", exp_done.size(), 0);

    // 2: per=10, dly=0, n=3.
    arm(10, 0, 3, t);
    end_burst(t + 31, 3);

    // 3: per below PULSE_W+1 is clamped to 5.
    arm(2, 5, 2, t);
    end_burst(t + 16, 2);

    // 4: zero pulses: done only.
    arm(10, 0, 0, t);
    end_burst(t + 1, 0);

    // 5: abort during pulse 2 high phase, then a full fresh burst.
    arm(10, 0, 5, t);
    wait_until(t + 22);
    kill(1'b0);
    arm(10, 0, 5, t);
    end_burst(t + 51, 5);

    // 6: start edge and config changes while busy have no effect.
    arm(10, 3, 3, t);
    wait_until(t + 8);
    start = 1'b0; sig_period = 7; start_delay = 0; pulse_count = 2;
    @(negedge clk);
    start = 1'b1;
    end_burst(t + 34, 3);
    arm(7, 0, 2, t);
    end_burst(t + 15, 2);

    // 7: reset mid-burst clears pulse_idx; start held high does not re-arm.
    arm(10, 0, 3, t);
    wait_until(t + 15);
    check("pre_rst_idx", 32'(pulse_idx), 1);
    kill(1'b1);
    repeat (8) @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
